alu_operand_pipe: RTL and testbench
===================================

Name: alu_operand_pipe

Overview:
- Operand-supply and writeback stage wrapped around the combinational ALU (ports A, B, ALUOp -> C).
- Holds a 32 x 32-bit general register file with $0 hardwired to zero.
- Accepts register-addressed operations (rs, rt, rd, op) through a valid/ready handshake and registers the operands into an execute stage that drives the ALU.
- Commits the ALU result C back into the file the following edge, with full bypassing and an external write port (load data) that takes priority.

Parameters:
WIDTH, 32, datapath width (matches ALU A/B/C)
AW, 5, register address width (2**AW registers)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high; clears all state
in_valid  in  1  operation request present
in_ready  out  1  stage can accept this cycle
in_rs  in  AW  source register for ALU A
in_rt  in  AW  source register for ALU B
in_rd  in  AW  destination register
in_op  in  3  ALU opcode (0 add, 1 sub, 2 and, 3 or, 4 srl, 5 sra, others -> 0)
alu_a  out  WIDTH  to ALU A (registered)
alu_b  out  WIDTH  to ALU B (registered)
alu_op  out  3  to ALU ALUOp (registered)
alu_c  in  WIDTH  from ALU C (combinational return)
ext_we  in  1  external write enable (load writeback)
ext_waddr  in  AW  external write address
ext_wdata  in  WIDTH  external write data
wb_valid  out  1  one-cycle pulse: ALU result committed
wb_rd  out  AW  committed destination
wb_data  out  WIDTH  committed value

Behaviour:
- Reset (clk edge with reset=1):
  - all registers = 0; ex_valid = 0; alu_a = alu_b = 0; alu_op = 0; wb_valid = 0; wb_rd = 0; wb_data = 0.
  - in_ready = 0 while reset is high.
  - Reset mid-operation discards any EX-stage operation; it is never written back.
- Handshake:
  - in_ready = !reset && !(ext_we && ex_valid).
  - An operation is accepted on an edge where in_valid && in_ready.
  - in_valid && !in_ready: requester holds its fields; nothing is captured.
- EX stage (registered), on accept:
  - ex_valid <= 1; alu_a <= opnd(in_rs); alu_b <= opnd(in_rt); alu_op <= in_op; ex_rd <= in_rd.
  - With no accept and no stall: ex_valid <= 0; alu_a/alu_b/alu_op hold their values.
- Operand select opnd(r), first match wins:
  - r == 0 -> 0.
  - ex_valid && ex_rd == r -> alu_c.
  - ext_we && ext_waddr == r -> ext_wdata.
  - otherwise regfile[r].
- Commit:
  - On an edge with ex_valid && !ext_we: regfile[ex_rd] <= alu_c (suppressed if ex_rd == 0); wb_valid <= 1; wb_rd <= ex_rd; wb_data <= alu_c (data reported even for rd = 0).
  - ex_valid clears unless a new op is accepted on the same edge (back-to-back throughput = 1 op/cycle).
- External write:
  - ext_we && ext_waddr != 0 -> regfile[ext_waddr] <= ext_wdata every edge, regardless of EX state.
  - If ext_we && ex_valid: EX stalls (holds alu_a/b/op, ex_rd, ex_valid); no commit; wb_valid <= 0.
  - The ALU result commits on the first edge with ext_we low.
- Simultaneous ext write and commit to the same register cannot occur (commit is stalled). A stalled EX result written later overwrites an earlier ext write to the same register.
- Latency:
  - Accept edge N -> alu_a/alu_b valid after N.
  - Commit and wb_valid high after N+1 (absent stall).
  - A dependent op accepted at N+1 sees the result through the bypass.
- wb_valid is high for exactly one cycle per committed op.
- Widths: no extension; all values are WIDTH bits; ALU semantics belong to the ALU.

Decomposition:
- Shared package: WIDTH/AW defaults and the ALU opcode constants (ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_SRL=4, ALU_SRA=5), shared with the ALU.
- One sub-module is natural: reg_file (2 async read, 1 write port, $0 = 0, no internal bypass). Arbitration of the ext/commit write and all bypass muxing stay in alu_operand_pipe.

Test Plan:
- Reset, then ext_we r1=7 and r2=3 (separate cycles); accept (rs=1, rt=2, rd=3, op=0) -> next cycle alu_a=7, alu_b=3, alu_op=0; following cycle wb_valid=1, wb_rd=3, wb_data=10.
- Back-to-back dependency: r3=10 being committed, accept (rs=3, rt=2, rd=4, op=1) in the same cycle -> alu_a=10 via bypass, wb_data=7, r4=7.
- $0 rules: accept rd=0, op=3 with r1|r2 -> wb_valid=1, wb_data=7, r0 still reads 0; ext_we to addr 0 with 0xFFFFFFFF -> r0 reads 0.
- Stall: ex_valid=1 and ext_we=1 for 2 cycles -> in_ready=0, alu_a/alu_b held, wb_valid=0; commit lands on the cycle after ext_we drops.
- Ext bypass: ext_we r5=0x80000000 in the same cycle as accept (rs=5, rt=2, op=5) -> alu_a=0x80000000, wb_data=0xF0000000.
- Reset asserted while ex_valid=1 -> no wb_valid; all registers read 0 afterwards; in_ready=0 during reset, 1 after.

Source files
------------

// File: rtl/alu_operand_pipe_pkg.sv
// alu_operand_pipe_pkg: shared widths and ALU opcode encoding for the operand pipe and the ALU
package alu_operand_pipe_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_AW = 5;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SRL = 3'd4,
    ALU_SRA = 3'd5
  } alu_op_e;
endpackage

// File: rtl/alu_operand_pipe_reg_file.sv
// alu_operand_pipe_reg_file: 2**AW x W register file, two async reads, one write, $0 reads zero
// Ports: clk/reset (sync, active-high clears all), we_i/waddr_i/wdata_i write port,
//        raddr_a_i/rdata_a_o and raddr_b_i/rdata_b_o read ports (no write-through bypass).
module alu_operand_pipe_reg_file
  import alu_operand_pipe_pkg::*;
#(
  parameter int W  = DEF_WIDTH,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [W-1:0]  rdata_a_o,
  output logic [W-1:0]  rdata_b_o
);
  logic [W-1:0] mem_q [2**AW];
  always_ff @(posedge clk) begin
    if (reset) mem_q <= '{default: '0};
    else if (we_i && waddr_i != '0) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_a_o = raddr_a_i == '0 ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = raddr_b_i == '0 ? '0 : mem_q[raddr_b_i];
endmodule

// File: rtl/alu_operand_pipe.sv
// alu_operand_pipe: register-file operand supply and writeback stage around a combinational ALU
// Ports: in_valid/in_ready handshake with in_rs/in_rt/in_rd/in_op; registered alu_a/alu_b/alu_op
//        to the ALU, alu_c back; ext_we/ext_waddr/ext_wdata load write port (has priority);
//        wb_valid/wb_rd/wb_data one-cycle commit report.
module alu_operand_pipe
  import alu_operand_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AW    = DEF_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs,
  input  logic [AW-1:0]    in_rt,
  input  logic [AW-1:0]    in_rd,
  input  logic [2:0]       in_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             ext_we,
  input  logic [AW-1:0]    ext_waddr,
  input  logic [WIDTH-1:0] ext_wdata,
  output logic             wb_valid,
  output logic [AW-1:0]    wb_rd,
  output logic [WIDTH-1:0] wb_data
);
  logic             ex_valid_q, ex_valid_d;
  logic [AW-1:0]    ex_rd_q, ex_rd_d, wb_rd_q, wb_rd_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, wb_data_q, wb_data_d;
  logic [2:0]       op_q, op_d;
  logic             wb_valid_q, wb_valid_d;
  logic             stall, accept, commit;
  logic [WIDTH-1:0] rf_a, rf_b, opnd_a, opnd_b;
  // The single write port is shared: a load write always wins and stalls any pending commit.
  assign stall    = ext_we && ex_valid_q;
  assign in_ready = !reset && !stall;
  assign accept   = in_valid && in_ready;
  assign commit   = ex_valid_q && !ext_we;
  alu_operand_pipe_reg_file #(.W(WIDTH), .AW(AW)) u_rf (
    .clk       (clk),
    .reset     (reset),
    .we_i      (ext_we || commit),
    .waddr_i   (ext_we ? ext_waddr : ex_rd_q),
    .wdata_i   (ext_we ? ext_wdata : alu_c),
    .raddr_a_i (in_rs),
    .raddr_b_i (in_rt),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b)
  );
  // Youngest value wins: the in-flight ALU result, then this cycle's load, then the file.
  assign opnd_a = in_rs == '0 ? '0 : (ex_valid_q && ex_rd_q == in_rs) ? alu_c :
                  (ext_we && ext_waddr == in_rs) ? ext_wdata : rf_a;
  assign opnd_b = in_rt == '0 ? '0 : (ex_valid_q && ex_rd_q == in_rt) ? alu_c :
                  (ext_we && ext_waddr == in_rt) ? ext_wdata : rf_b;
  always_comb begin
    ex_valid_d = stall || accept;
    ex_rd_d    = accept ? in_rd : ex_rd_q;
    a_d        = accept ? opnd_a : a_q;
    b_d        = accept ? opnd_b : b_q;
    op_d       = accept ? in_op : op_q;
    wb_valid_d = commit;
    wb_rd_d    = commit ? ex_rd_q : wb_rd_q;
    wb_data_d  = commit ? alu_c : wb_data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q <= 1'b0;
      ex_rd_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_rd_q    <= ex_rd_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
endmodule

// File: tb/tb_alu_operand_pipe.sv
// tb_alu_operand_pipe: directed and randomized checks of alu_operand_pipe against a behavioural model
module tb_alu_operand_pipe;
  logic        clk = 0;
  logic        reset = 1;
  logic        in_valid = 0, in_ready;
  logic [4:0]  in_rs = 0, in_rt = 0, in_rd = 0;
  logic [2:0]  in_op = 0;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_op;
  logic        ext_we = 0;
  logic [4:0]  ext_waddr = 0;
  logic [31:0] ext_wdata = 0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  int pass = 0, total = 0;

  logic [31:0] mreg [32];
  logic        m_exv = 0, m_wbv = 0;
  logic [31:0] m_a = 0, m_b = 0, m_wbdata = 0;
  logic [2:0]  m_op = 0;
  logic [4:0]  m_rd = 0, m_wbrd = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a >> b[4:0];
      3'd5: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  assign alu_c = alu_f(alu_a, alu_b, alu_op);

  alu_operand_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .ext_we(ext_we), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  function automatic logic [31:0] opnd(logic [4:0] r, logic [31:0] res);
    if (r == 0) return 0;
    if (m_exv && m_rd == r) return res;
    if (ext_we && ext_waddr == r) return ext_wdata;
    return mreg[r];
  endfunction

  task automatic cycle();
    logic rdy, acc, com;
    logic [31:0] res, na, nb;
    #1;
    rdy = !reset && !(ext_we && m_exv);
    total++; if (in_ready !== rdy) $display("FAIL in_ready got %0b exp %0b t=%0t", in_ready, rdy, $time); else pass++;
    res = alu_f(m_a, m_b, m_op);
    acc = in_valid && rdy;
    com = m_exv && !ext_we;
    na = opnd(in_rs, res);
    nb = opnd(in_rt, res);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) mreg[i] = 0;
      m_exv = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_wbv = 0; m_wbrd = 0; m_wbdata = 0;
    end else begin
      if (com && m_rd != 0) mreg[m_rd] = res;
      if (ext_we && ext_waddr != 0) mreg[ext_waddr] = ext_wdata;
      m_wbv = com;
      if (com) begin m_wbrd = m_rd; m_wbdata = res; end
      m_exv = acc || (ext_we && m_exv);
      if (acc) begin m_a = na; m_b = nb; m_op = in_op; m_rd = in_rd; end
    end
    #1;
    total++; if (alu_a !== m_a) $display("FAIL model_alu_a got %h exp %h t=%0t", alu_a, m_a, $time); else pass++;
    total++; if (alu_b !== m_b) $display("FAIL model_alu_b got %h exp %h t=%0t", alu_b, m_b, $time); else pass++;
    total++; if (alu_op !== m_op) $display("FAIL model_alu_op got %0d exp %0d t=%0t", alu_op, m_op, $time); else pass++;
    total++; if (wb_valid !== m_wbv) $display("FAIL model_wb_valid got %0b exp %0b t=%0t", wb_valid, m_wbv, $time); else pass++;
    if (m_wbv) begin
      total++; if (wb_rd !== m_wbrd) $display("FAIL model_wb_rd got %0d exp %0d t=%0t", wb_rd, m_wbrd, $time); else pass++;
      total++; if (wb_data !== m_wbdata) $display("FAIL model_wb_data got %h exp %h t=%0t", wb_data, m_wbdata, $time); else pass++;
    end
  endtask

  task automatic op(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [2:0] o);
    in_valid = 1; in_rs = rs; in_rt = rt; in_rd = rd; in_op = o;
  endtask

  task automatic test_reset();
    reset = 1;
    cycle(); cycle();
    total++; if (in_ready !== 0) $display("FAIL reset_ready got %0b exp 0", in_ready); else pass++;
    total++; if (alu_a !== 0 || alu_b !== 0 || alu_op !== 0) $display("FAIL reset_alu got %h %h %0d exp 0 0 0", alu_a, alu_b, alu_op); else pass++;
    total++; if (wb_valid !== 0 || wb_rd !== 0 || wb_data !== 0) $display("FAIL reset_wb got %0b %0d %h exp 0 0 0", wb_valid, wb_rd, wb_data); else pass++;
    reset = 0;
    #1;
    total++; if (in_ready !== 1) $display("FAIL reset_release_ready got %0b exp 1", in_ready); else pass++;
  endtask

  task automatic test_basic();
    ext_we = 1; ext_waddr = 1; ext_wdata = 7; cycle();
    ext_waddr = 2; ext_wdata = 3; cycle();
    ext_we = 0; op(1, 2, 3, 0); cycle();
    total++; if (alu_a !== 7 || alu_b !== 3 || alu_op !== 0) $display("FAIL basic_operands got %h %h %0d exp 7 3 0", alu_a, alu_b, alu_op); else pass++;
  endtask

  task automatic test_back_to_back();
    op(3, 2, 4, 1); cycle();
    total++; if (wb_valid !== 1 || wb_rd !== 3 || wb_data !== 10) $display("FAIL b2b_first_wb got %0b %0d %h exp 1 3 a", wb_valid, wb_rd, wb_data); else pass++;
    total++; if (alu_a !== 10 || alu_b !== 3 || alu_op !== 1) $display("FAIL b2b_bypass got %h %h %0d exp a 3 1", alu_a, alu_b, alu_op); else pass++;
    in_valid = 0; cycle();
    total++; if (wb_valid !== 1 || wb_rd !== 4 || wb_data !== 7) $display("FAIL b2b_second_wb got %0b %0d %h exp 1 4 7", wb_valid, wb_rd, wb_data); else pass++;
    op(4, 0, 0, 0); cycle();
    total++; if (alu_a !== 7) $display("FAIL b2b_r4_read got %h exp 7", alu_a); else pass++;
  endtask

  task automatic test_zero();
    op(1, 2, 0, 3); cycle();
    in_valid = 0; cycle();
    total++; if (wb_valid !== 1 || wb_rd !== 0 || wb_data !== 7) $display("FAIL zero_rd_wb got %0b %0d %h exp 1 0 7", wb_valid, wb_rd, wb_data); else pass++;
    ext_we = 1; ext_waddr = 0; ext_wdata = 32'hFFFF_FFFF; cycle();
    ext_we = 0; op(0, 0, 0, 3); cycle();
    total++; if (alu_a !== 0 || alu_b !== 0) $display("FAIL zero_r0_read got %h %h exp 0 0", alu_a, alu_b); else pass++;
    in_valid = 0; cycle();
  endtask

  task automatic test_stall();
    op(1, 2, 6, 0); cycle();
    ext_we = 1; ext_waddr = 7; ext_wdata = 5; op(1, 1, 8, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (in_ready !== 0) $display("FAIL stall_ready got %0b exp 0", in_ready); else pass++;
      cycle();
      total++; if (wb_valid !== 0 || alu_a !== 7 || alu_b !== 3) $display("FAIL stall_hold got %0b %h %h exp 0 7 3", wb_valid, alu_a, alu_b); else pass++;
    end
    ext_we = 0; cycle();
    total++; if (wb_valid !== 1 || wb_rd !== 6 || wb_data !== 10) $display("FAIL stall_commit got %0b %0d %h exp 1 6 a", wb_valid, wb_rd, wb_data); else pass++;
    total++; if (alu_a !== 7 || alu_b !== 7) $display("FAIL stall_held_accept got %h %h exp 7 7", alu_a, alu_b); else pass++;
    in_valid = 0; cycle();
    total++; if (wb_valid !== 1 || wb_rd !== 8 || wb_data !== 14) $display("FAIL stall_next_wb got %0b %0d %h exp 1 8 e", wb_valid, wb_rd, wb_data); else pass++;
    cycle();
  endtask

  task automatic test_ext_bypass();
    ext_we = 1; ext_waddr = 5; ext_wdata = 32'h8000_0000; op(5, 2, 9, 5); cycle();
    total++; if (alu_a !== 32'h8000_0000 || alu_b !== 3) $display("FAIL extbyp_operands got %h %h exp 80000000 3", alu_a, alu_b); else pass++;
    ext_we = 0; in_valid = 0; cycle();
    total++; if (wb_valid !== 1 || wb_rd !== 9 || wb_data !== 32'hF000_0000) $display("FAIL extbyp_wb got %0b %0d %h exp 1 9 f0000000", wb_valid, wb_rd, wb_data); else pass++;
  endtask

  task automatic test_reset_mid();
    op(1, 2, 10, 0); cycle();
    in_valid = 0; reset = 1;
    #1;
    total++; if (in_ready !== 0) $display("FAIL midreset_ready got %0b exp 0", in_ready); else pass++;
    cycle();
    total++; if (wb_valid !== 0) $display("FAIL midreset_wb got %0b exp 0", wb_valid); else pass++;
    cycle();
    reset = 0;
    #1;
    total++; if (in_ready !== 1) $display("FAIL midreset_release got %0b exp 1", in_ready); else pass++;
    for (int r = 1; r < 32; r++) begin
      op(r[4:0], r[4:0], 0, 0); cycle();
      total++; if (alu_a !== 0 || alu_b !== 0) $display("FAIL midreset_reg%0d got %h %h exp 0 0", r, alu_a, alu_b); else pass++;
    end
    in_valid = 0; cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      in_rs = 5'($urandom_range(0, 7));
      in_rt = 5'($urandom_range(0, 7));
      in_rd = 5'($urandom_range(0, 7));
      in_op = 3'($urandom_range(0, 7));
      ext_we = $urandom_range(0, 2) == 0;
      ext_waddr = 5'($urandom_range(0, 7));
      ext_wdata = $urandom;
      cycle();
    end
    reset = 0; in_valid = 0; ext_we = 0;
    cycle(); cycle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_zero();
    test_stall();
    test_ext_bypass();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
